// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller.
// Frame FSM states, sync default and command byte fields.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_CSUM,
    S_RESP
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hAA;

  localparam int CMD_WR      = 7;
  localparam int CMD_RSV_HI  = 6;
  localparam int CMD_RSV_LO  = 2;
  localparam int CMD_ADDR_HI = 1;
  localparam int CMD_ADDR_LO = 0;

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle counter for the UART command controller.
// Flags expiry after TIMEOUT_CYCLES enabled cycles without a clear.
module frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 104000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [19:0] LAST = 20'(TIMEOUT_CYCLES - 1);

  logic [19:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 20'd1;
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_controller.sv
// Frame-level UART command controller: sync hunt, command decode,
// XOR checksum, 4-byte register file and read response handshake.
module uart_cmd_controller
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 104000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_update,
  output logic [31:0] regs_out,
  output logic [3:0]  wr_strobe,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  state_t state, state_n;

  logic [3:0][7:0] regs;
  logic            cmd_wr;
  logic [1:0]      cmd_addr;
  logic [7:0]      data_q;
  logic [7:0]      csum_q;

  logic ok_n, err_n, wr_n;
  logic ld_cmd, ld_data, ld_tx, tx_clr;
  logic counting, expired, rsv_bad;

  assign regs_out = regs;
  assign rsv_bad  = |rx_data[CMD_RSV_HI:CMD_RSV_LO];
  assign counting = (state == S_CMD) ||
                    (state == S_DATA) ||
                    (state == S_CSUM);

  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_update || !counting),
    .enable (counting),
    .expired(expired)
  );

  always_comb begin
    state_n = state;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    wr_n    = 1'b0;
    ld_cmd  = 1'b0;
    ld_data = 1'b0;
    ld_tx   = 1'b0;
    tx_clr  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rx_update && rx_data == SYNC_BYTE)
          state_n = S_CMD;
      end
      S_CMD: begin
        if (rx_update) begin
          if (rsv_bad) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            ld_cmd  = 1'b1;
            state_n = rx_data[CMD_WR] ? S_DATA : S_CSUM;
          end
        end else if (expired) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_update) begin
          ld_data = 1'b1;
          state_n = S_CSUM;
        end else if (expired) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_CSUM: begin
        state_n = S_IDLE;
        if (rx_update) begin
          if (rx_data != csum_q) begin
            err_n = 1'b1;
          end else if (cmd_wr) begin
            wr_n = 1'b1;
            ok_n = 1'b1;
          end else begin
            ld_tx   = 1'b1;
            ok_n    = 1'b1;
            state_n = S_RESP;
          end
        end else if (expired) begin
          err_n = 1'b1;
        end else begin
          state_n = S_CSUM;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          tx_clr  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      regs      <= '0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      data_q    <= '0;
      csum_q    <= '0;
      wr_strobe <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      frame_ok  <= ok_n;
      frame_err <= err_n;
      wr_strobe <= wr_n ? (4'b0001 << cmd_addr) : 4'b0000;
      if (ld_cmd) begin
        cmd_wr   <= rx_data[CMD_WR];
        cmd_addr <= rx_data[CMD_ADDR_HI:CMD_ADDR_LO];
        csum_q   <= SYNC_BYTE ^ rx_data;
      end
      if (ld_data) begin
        data_q <= rx_data;
        csum_q <= csum_q ^ rx_data;
      end
      if (wr_n)
        regs[cmd_addr] <= data_q;
      if (ld_tx) begin
        tx_data  <= regs[cmd_addr];
        tx_valid <= 1'b1;
      end else if (tx_clr) begin
        tx_valid <= 1'b0;
      end
      if (err_n && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Self-checking bench for uart_cmd_controller.
// Frame vector table plus hand sequences, event scoreboard.
module tb_uart_cmd_controller;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_update;
  logic [31:0] regs_out;
  logic [3:0]  wr_strobe;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        frame_ok;
  logic        frame_err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  uart_cmd_controller #(
    .TIMEOUT_CYCLES(T),
    .SYNC_BYTE     (8'hAA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_update(rx_update),
    .regs_out (regs_out),
    .wr_strobe(wr_strobe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_count(err_count)
  );

  typedef struct {
    logic       ok;
    logic       err;
    logic [3:0] strobe;
  } ev_t;

  typedef struct {
    logic [63:0] b;
    int          n;
    logic        ok;
    logic        err;
    logic [3:0]  strobe;
    logic        rd;
    logic [7:0]  rdv;
    logic [31:0] regs;
    logic [7:0]  errc;
  } vec_t;

  ev_t        evq [$];
  logic [7:0] rdq [$];
  vec_t       vq  [$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push_ev(input logic ok, input logic err,
                         input logic [3:0] s);
    ev_t e;
    e.ok = ok;
    e.err = err;
    e.strobe = s;
    evq.push_back(e);
  endtask

  // One clock: handshake sampled mid-cycle, pulses after the edge
  task automatic tick();
    logic       hs;
    logic [7:0] hsd;
    ev_t        e;
    @(negedge clk);
    hs  = tx_valid && tx_ready;
    hsd = tx_data;
    @(posedge clk);
    #1;
    chk("ok_err_excl", 32'(frame_ok & frame_err), 0);
    if (frame_ok || frame_err) begin
      if (evq.size() == 0) begin
        chk("unexpected_evt",
            {26'd0, frame_ok, frame_err, wr_strobe}, 0);
      end else begin
        e = evq.pop_front();
        chk("evt", {26'd0, frame_ok, frame_err, wr_strobe},
            {26'd0, e.ok, e.err, e.strobe});
      end
    end else begin
      chk("stray_strobe", 32'(wr_strobe), 0);
    end
    if (hs) begin
      if (rdq.size() == 0)
        chk("unexpected_tx", 32'(hsd), 32'hFFFF_FFFF);
      else
        chk("tx_data", 32'(hsd), 32'(rdq.pop_front()));
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data   = b;
    rx_update = 1'b1;
    tick();
    rx_update = 1'b0;
  endtask

  task automatic addv(input logic [63:0] b, input int n,
                      input logic ok, input logic err,
                      input logic [3:0] s, input logic rd,
                      input logic [7:0] rv,
                      input logic [31:0] r,
                      input logic [7:0] e);
    vec_t v;
    v.b = b; v.n = n; v.ok = ok; v.err = err;
    v.strobe = s; v.rd = rd; v.rdv = rv;
    v.regs = r; v.errc = e;
    vq.push_back(v);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_regs"}, regs_out, 0);
    chk({tag, "_ctl"},
        {25'd0, wr_strobe, tx_valid, frame_ok, frame_err}, 0);
    chk({tag, "_tx"}, 32'(tx_data), 0);
    chk({tag, "_errc"}, 32'(err_count), 0);
  endtask

  initial begin
    vec_t v;
    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_update = 1'b0;
    tx_ready  = 1'b0;
    #23;
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    addv(64'hAA825C74_00000000, 4, 1, 0, 4'b0100, 0, 0,
         32'h005C0000, 0);
    addv(64'hAA813300_00000000, 4, 0, 1, 0, 0, 0,
         32'h005C0000, 1);
    addv(64'h00FF55AA_83113800, 7, 1, 0, 4'b1000, 0, 0,
         32'h115C0000, 1);
    addv(64'hAA840000_00000000, 2, 0, 1, 0, 0, 0,
         32'h115C0000, 2);
    addv(64'hAAAA0000_00000000, 2, 0, 1, 0, 0, 0,
         32'h115C0000, 3);
    addv(64'hAA80C3E9_00000000, 4, 1, 0, 4'b0001, 0, 0,
         32'h115C00C3, 3);
    addv(64'hAA817E55_00000000, 4, 1, 0, 4'b0010, 0, 0,
         32'h115C7EC3, 3);
    addv(64'hAA01AB00_00000000, 3, 1, 0, 0, 1, 8'h7E,
         32'h115C7EC3, 3);
    addv(64'hAA03A900_00000000, 3, 1, 0, 0, 1, 8'h11,
         32'h115C7EC3, 3);
    addv(64'hAA010000_00000000, 3, 0, 1, 0, 0, 0,
         32'h115C7EC3, 4);
    addv(64'hAA00AA00_00000000, 3, 1, 0, 0, 1, 8'hC3,
         32'h115C7EC3, 4);

    tx_ready = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      if (v.ok || v.err) push_ev(v.ok, v.err, v.strobe);
      if (v.rd) rdq.push_back(v.rdv);
      for (int k = 0; k < v.n; k++)
        send(v.b[63-8*k -: 8]);
      repeat (3) tick();
      chk($sformatf("vec%0d_regs", i), regs_out, v.regs);
      chk($sformatf("vec%0d_errc", i), 32'(err_count),
          32'(v.errc));
      chk($sformatf("vec%0d_txv", i), 32'(tx_valid), 0);
    end

    // Read with backpressure; a byte arriving in RESP is dropped
    tx_ready = 1'b0;
    push_ev(1, 0, 0);
    send(8'hAA); send(8'h02); send(8'hA8);
    chk("bp_hold0", {23'd0, tx_valid, tx_data}, 32'h15C);
    send(8'hAA);
    chk("bp_hold1", {23'd0, tx_valid, tx_data}, 32'h15C);
    for (int i = 2; i < 10; i++) begin
      tick();
      chk("bp_hold", {23'd0, tx_valid, tx_data}, 32'h15C);
    end
    rdq.push_back(8'h5C);
    tx_ready = 1'b1;
    tick();
    chk("bp_release", 32'(tx_valid), 0);
    send(8'h02); send(8'hA8);
    repeat (3) tick();
    chk("bp_errc", 32'(err_count), 4);

    // Timeout inside a write frame, then a good frame
    push_ev(0, 1, 0);
    send(8'hAA); send(8'h81);
    repeat (T - 1) tick();
    chk("to_early", 32'(err_count), 4);
    tick();
    chk("to_fire", 32'(err_count), 5);
    push_ev(1, 0, 4'b1000);
    send(8'hAA); send(8'h83); send(8'h22); send(8'h0B);
    tick();
    chk("to_after", regs_out, 32'h225C7EC3);

    // Bytes landing exactly on the expiry cycle win
    push_ev(1, 0, 4'b0010);
    send(8'hAA); send(8'h81);
    repeat (T - 1) tick();
    send(8'h44);
    repeat (T - 1) tick();
    send(8'h6F);
    tick();
    chk("race_regs", regs_out, 32'h225C44C3);
    chk("race_errc", 32'(err_count), 5);

    // Error counter saturation
    repeat (260) begin
      push_ev(0, 1, 0);
      send(8'hAA); send(8'h84);
    end
    tick();
    chk("sat_errc", 32'(err_count), 32'hFF);

    // Reset mid-frame, then a good frame
    send(8'hAA); send(8'h80);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push_ev(1, 0, 4'b0010);
    send(8'hAA); send(8'h81); send(8'h7E); send(8'h55);
    tick();
    chk("post_rst_regs", regs_out, 32'h00007E00);
    chk("post_rst_errc", 32'(err_count), 0);

    repeat (3) tick();
    chk("evq_drained", 32'(evq.size()), 0);
    chk("rdq_drained", 32'(rdq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_controller.md
# uart_cmd_controller

Frame-level controller that sits downstream of the UART byte receiver and turns its byte stream into register accesses. It hunts for a sync byte, decodes a command byte, checks an XOR checksum, and then does one of two things. A write commits a byte to a 4-entry configuration register file. A read returns one register byte over a valid/ready handshake toward a UART transmitter. The block also enforces an inter-byte timeout and keeps a saturating error counter.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 104000: maximum idle clocks between bytes inside a frame. The default is 2 byte times at 9600 baud / 50 MHz. Legal range 1..2^20-1.
- `SYNC_BYTE`, default 8'hAA: frame start marker.

Ports:
- `clk` in 1: single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: byte from the receiver; valid only while `rx_update` is high.
- `rx_update` in 1: one-cycle pulse per received byte.
- `regs_out` out 32: register file, reg *n* at bits [8n+7:8n].
- `wr_strobe` out 4: one-hot, 1-cycle pulse on the register just written.
- `tx_data` out 8: read response byte.
- `tx_valid` out 1: response valid; held until accepted.
- `tx_ready` in 1: transmitter accepts `tx_data` on any edge where `tx_valid && tx_ready`.
- `frame_ok` out 1: 1-cycle pulse when a frame is accepted.
- `frame_err` out 1: 1-cycle pulse when a frame is rejected.
- `err_count` out 8: number of rejected frames, saturating at 255.

## Operation
Frame format:
- Write frame: SYNC, CMD, DATA, CSUM, where CSUM = SYNC^CMD^DATA.
- Read frame: SYNC, CMD, CSUM, where CSUM = SYNC^CMD.
- CMD[7] = 1 for write, 0 for read. CMD[1:0] = register address. CMD[6:2] must be 0.

States:
- IDLE
  - On `rx_update` with byte == SYNC_BYTE, go to CMD.
  - Any other byte is silently ignored; this is not an error.
- CMD
  - Reserved bits nonzero: `frame_err`, go to IDLE. No resync on this byte, even if it equals SYNC.
  - Otherwise latch the command and the running XOR. Go to DATA for a write or CSUM for a read.
- DATA: latch the byte, update the XOR, go to CSUM.
- CSUM
  - Mismatch: `frame_err`, go to IDLE.
  - Match on a write: write the register, pulse `wr_strobe` and `frame_ok`, go to IDLE.
  - Match on a read: load `tx_data` from the register, set `tx_valid`, pulse `frame_ok`, go to RESP.
- RESP
  - Hold `tx_data` and `tx_valid` stable.
  - On an edge with `tx_ready` high, clear `tx_valid` and go to IDLE.
  - `rx_update` pulses in RESP are dropped with no error.

Timeout:
- The counter is cleared on every `rx_update` and in IDLE and RESP. It counts in CMD, DATA and CSUM.
- On reaching TIMEOUT_CYCLES with no byte: `frame_err`, go to IDLE.
- If `rx_update` and timeout expiry land on the same cycle, the byte wins: it is processed and the counter is cleared.

Error counter:
- Increments by 1 on each `frame_err` and holds at 255.
- There is no clear other than reset.

Reset (`rst_n` low, asynchronous):
- State returns to IDLE and all registers go to 0x00.
- All outputs are 0: `regs_out`, `wr_strobe`, `tx_data`, `tx_valid`, `frame_ok`, `frame_err`, `err_count`.
- A frame in progress is aborted with no partial write and no error count.

## Timing
- Every decision is taken at the clock edge E that samples `rx_update` = 1. The state, register and response updates all take effect at E.
- Write frame: the new `regs_out` value, `wr_strobe[a]` and `frame_ok` are visible in the cycle after E. The pulses are exactly one cycle wide.
- Read frame: `tx_valid` rises in the cycle after E. It falls in the cycle after the first edge with `tx_ready` = 1.
- Minimum read turnaround is 1 cycle, when `tx_ready` is already high.
- `frame_ok` and `frame_err` are never high together.
- Back-to-back frames: the controller is in IDLE the cycle after a write commit, so a SYNC byte on the very next `rx_update` is accepted.

## Structure
- Package `uart_cmd_pkg` holds:
  - the state enum (IDLE, CMD, DATA, CSUM, RESP);
  - the default SYNC value;
  - the CMD field positions (write bit 7, reserved bits 6:2, address bits 1:0).
- Sub-module `frame_timer`: a 20-bit counter with inputs clear and enable and output `expired`, parameterised by TIMEOUT_CYCLES.
- Everything else (FSM, register file, error counter, response register) stays in the top module.

## Test plan
- Write frame: bytes AA 82 5C 74 → `regs_out[23:16]` = 5C, `wr_strobe` = 0100 for 1 cycle, `frame_ok` for 1 cycle, `err_count` = 0.
- Read with backpressure: after the write above, send AA 02 A8 and hold `tx_ready` low for 10 cycles. `tx_valid` = 1 and `tx_data` = 5C must stay stable throughout. `tx_valid` = 0 the cycle after `tx_ready` is raised.
- Checksum error: AA 81 33 00 → no `wr_strobe`, reg1 unchanged, `frame_err` pulse, `err_count` = 1.
- Timeout, then a good frame:
  - Send AA 81, then idle for TIMEOUT_CYCLES → `frame_err`, `err_count` increments, back to IDLE.
  - Then send AA 83 11 38 → reg3 = 11.
- Garbage and reserved bits:
  - 00 FF 55 before AA 83 11 38 → accepted, `err_count` unchanged.
  - AA 84 → `frame_err`.
- Saturation and reset:
  - 260 bad frames → `err_count` = FF.
  - Assert `rst_n` low mid-frame after AA 80 → all outputs 0, and a following good frame is accepted.
